// File: rtl/im_bank_responder_if.sv
// Request/response and load bus between the spatial encoder (master) and one
// modality's iM / projM bank responder (slave).
interface im_bank_responder_if #(
  parameter int unsigned HV_DIM = 2000,
  parameter int unsigned ADDR_W = 8
);
  logic              Req_SI;
  logic [ADDR_W-1:0] ReqAddr_DI;
  logic              RespValid_SO;
  logic [HV_DIM-1:0] IMOut_DO;
  logic [HV_DIM-1:0] ProjNeg_DO;
  logic [HV_DIM-1:0] ProjPos_DO;
  logic              LoadEn_SI;
  logic [1:0]        LoadSel_DI;
  logic [ADDR_W-1:0] LoadAddr_DI;
  logic [HV_DIM-1:0] LoadData_DI;
  logic              LoadReady_SO;

  modport master (
    output Req_SI, ReqAddr_DI, LoadEn_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI,
    input  RespValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO, LoadReady_SO
  );

  modport slave (
    input  Req_SI, ReqAddr_DI, LoadEn_SI, LoadSel_DI, LoadAddr_DI, LoadData_DI,
    output RespValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO, LoadReady_SO
  );
endinterface

// File: rtl/im_bank_responder.sv
// Per-modality iM / projM_neg / projM_pos row banks with a fixed-latency fetch port.
// Define IM_PARITY_EN to store an even-parity bit per row and expose sticky ParErr_SO.
module im_bank_responder #(
  parameter int unsigned HV_DIM       = 2000,
  parameter int unsigned DEPTH        = 214,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic               Clk_CI,
  input  logic               Reset_RI,
  im_bank_responder_if.slave bus,
  output logic               AddrErr_SO
`ifdef IM_PARITY_EN
  ,
  output logic               ParErr_SO
`endif
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      LAT_M1  = 4'(READ_LATENCY - 1);

  logic [HV_DIM-1:0] im_mem  [DEPTH];
  logic [HV_DIM-1:0] neg_mem [DEPTH];
  logic [HV_DIM-1:0] pos_mem [DEPTH];
`ifdef IM_PARITY_EN
  logic              im_par_mem  [DEPTH];
  logic              neg_par_mem [DEPTH];
  logic              pos_par_mem [DEPTH];
  logic              par_err_q, par_err_d;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [HV_DIM-1:0] im_out_q, im_out_d;
  logic [HV_DIM-1:0] neg_out_q, neg_out_d;
  logic [HV_DIM-1:0] pos_out_q, pos_out_d;
  logic              addr_err_q, addr_err_d;
  logic              req_in_range, load_in_range, accept, capture, load_we;

  assign req_in_range  = {1'b0, bus.ReqAddr_DI} < DEPTH_C;
  assign load_in_range = {1'b0, bus.LoadAddr_DI} < DEPTH_C;
  assign load_we       = (state_q == IDLE) && !Reset_RI && bus.LoadEn_SI &&
                         (bus.LoadSel_DI != 2'd3) && load_in_range;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    cnt_d        = cnt_q;
    im_out_d     = im_out_q;
    neg_out_d    = neg_out_q;
    pos_out_d    = pos_out_q;
    addr_err_d   = addr_err_q;
    accept       = 1'b0;
    capture      = 1'b0;
`ifdef IM_PARITY_EN
    par_err_d    = par_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.LoadEn_SI) begin
          if ((bus.LoadSel_DI != 2'd3) && !load_in_range) addr_err_d = 1'b1;
        end else if (bus.Req_SI) begin
          if (req_in_range) accept = 1'b1;
          else              addr_err_d = 1'b1;
        end
      end
      READ, HOLD: begin
        if (!bus.Req_SI) begin
          state_d = IDLE;
        end else if (bus.ReqAddr_DI != fetch_addr_q) begin
          if (req_in_range) begin
            accept = 1'b1;
          end else begin
            addr_err_d = 1'b1;
            state_d    = IDLE;
          end
        end else if (state_q == READ) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) capture = 1'b1;
        end
      end
    endcase

    // The counter reaches zero on the capture edge itself, so a one-cycle
    // latency captures straight from the accepting cycle and skips READ.
    if (accept) begin
      fetch_addr_d = bus.ReqAddr_DI;
      cnt_d        = LAT_M1;
      if (LAT_M1 == 4'd0) capture = 1'b1;
      else                state_d = READ;
    end

    if (capture) begin
      state_d   = HOLD;
      im_out_d  = im_mem[fetch_addr_d];
      neg_out_d = neg_mem[fetch_addr_d];
      pos_out_d = pos_mem[fetch_addr_d];
`ifdef IM_PARITY_EN
      if (((^im_out_d)  != im_par_mem[fetch_addr_d])  ||
          ((^neg_out_d) != neg_par_mem[fetch_addr_d]) ||
          ((^pos_out_d) != pos_par_mem[fetch_addr_d]))
        par_err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      cnt_q        <= '0;
      im_out_q     <= '0;
      neg_out_q    <= '0;
      pos_out_q    <= '0;
      addr_err_q   <= 1'b0;
`ifdef IM_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      cnt_q        <= cnt_d;
      im_out_q     <= im_out_d;
      neg_out_q    <= neg_out_d;
      pos_out_q    <= pos_out_d;
      addr_err_q   <= addr_err_d;
`ifdef IM_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  // Bank contents survive reset.
  always_ff @(posedge Clk_CI) begin
    if (load_we) begin
      unique case (bus.LoadSel_DI)
        2'd0: begin
          im_mem[bus.LoadAddr_DI] <= bus.LoadData_DI;
`ifdef IM_PARITY_EN
          im_par_mem[bus.LoadAddr_DI] <= ^bus.LoadData_DI;
`endif
        end
        2'd1: begin
          neg_mem[bus.LoadAddr_DI] <= bus.LoadData_DI;
`ifdef IM_PARITY_EN
          neg_par_mem[bus.LoadAddr_DI] <= ^bus.LoadData_DI;
`endif
        end
        2'd2: begin
          pos_mem[bus.LoadAddr_DI] <= bus.LoadData_DI;
`ifdef IM_PARITY_EN
          pos_par_mem[bus.LoadAddr_DI] <= ^bus.LoadData_DI;
`endif
        end
        default: ;
      endcase
    end
  end

  // Valid drops combinationally as soon as the encoder moves to a new address.
  assign bus.RespValid_SO = (state_q == HOLD) && bus.Req_SI && (bus.ReqAddr_DI == fetch_addr_q);
  assign bus.LoadReady_SO = (state_q == IDLE);
  assign bus.IMOut_DO     = im_out_q;
  assign bus.ProjNeg_DO   = neg_out_q;
  assign bus.ProjPos_DO   = pos_out_q;
  assign AddrErr_SO       = addr_err_q;
`ifdef IM_PARITY_EN
  assign ParErr_SO        = par_err_q;
`endif

endmodule

// File: tb/tb_im_bank_responder.sv
// Bench for im_bank_responder: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a timestamp-based reference model.
module tb_im_bank_responder;
  localparam int unsigned HV_DIM = 2000;
  localparam int unsigned DEPTH  = 214;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LAT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic addr_err;
`ifdef IM_PARITY_EN
  logic par_err;
`endif
  int n_checks = 0;
  int n_pass   = 0;

  im_bank_responder_if #(.HV_DIM(HV_DIM), .ADDR_W(ADDR_W)) bus ();

  im_bank_responder #(
    .HV_DIM(HV_DIM), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LATENCY(LAT)
  ) dut (
    .Clk_CI(clk),
    .Reset_RI(rst),
    .bus(bus),
    .AddrErr_SO(addr_err)
`ifdef IM_PARITY_EN
    ,
    .ParErr_SO(par_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fold(input logic [HV_DIM-1:0] v);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < int'(HV_DIM); i++) f[i % 64] = f[i % 64] ^ v[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [HV_DIM-1:0] got, input logic [HV_DIM-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (64-bit xor fold)", name, fold(got), fold(want));
  endtask

  function automatic logic [HV_DIM-1:0] rnd_hv();
    logic [HV_DIM-1:0] v;
    v = '0;
    for (int i = 0; i < 63; i++) v = {v[HV_DIM-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic int unsigned pick_addr();
    return ($urandom_range(0, 9) != 0) ? $urandom_range(0, 31) : $urandom_range(214, 255);
  endfunction

  // Reference model: a fetch "run" starts when a request is accepted; data is
  // due LAT cycles later provided Req stayed high on the same address.
  logic [HV_DIM-1:0] m_mem [3][DEPTH];
  bit                m_bad [3][DEPTH];
  logic [HV_DIM-1:0] m_out [3];
  bit     m_init = 0, m_live = 0, m_err = 0, m_par = 0, was_live, exp_valid;
  int     m_addr = 0, req_a, ld_a, ld_s;
  longint m_start = 0, cyc = 0;

  always @(negedge clk) begin
    req_a = int'(bus.ReqAddr_DI);
    ld_a  = int'(bus.LoadAddr_DI);
    ld_s  = int'(bus.LoadSel_DI);
    if (m_init) begin
      exp_valid = m_live && bus.Req_SI && (req_a == m_addr) && (cyc >= m_start + longint'(LAT));
      chk("resp_valid", HV_DIM'(bus.RespValid_SO), HV_DIM'(exp_valid));
      chk("load_ready", HV_DIM'(bus.LoadReady_SO), HV_DIM'(!m_live));
      chk("addr_err",   HV_DIM'(addr_err),         HV_DIM'(m_err));
      chk("im_out",     bus.IMOut_DO,   m_out[0]);
      chk("neg_out",    bus.ProjNeg_DO, m_out[1]);
      chk("pos_out",    bus.ProjPos_DO, m_out[2]);
`ifdef IM_PARITY_EN
      chk("par_err",    HV_DIM'(par_err), HV_DIM'(m_par));
`endif
    end
    if (rst) begin
      m_init = 1; m_live = 0; m_err = 0; m_par = 0;
      for (int b = 0; b < 3; b++) m_out[b] = '0;
    end else if (m_init) begin
      was_live = m_live;
      if (was_live) begin
        if (!bus.Req_SI) m_live = 0;
        else if (req_a != m_addr) begin
          if (req_a < int'(DEPTH)) begin m_addr = req_a; m_start = cyc; end
          else begin m_err = 1; m_live = 0; end
        end
      end else if (bus.LoadEn_SI) begin
        if (ld_s != 3) begin
          if (ld_a < int'(DEPTH)) begin m_mem[ld_s][ld_a] = bus.LoadData_DI; m_bad[ld_s][ld_a] = 0; end
          else m_err = 1;
        end
      end else if (bus.Req_SI) begin
        if (req_a < int'(DEPTH)) begin m_live = 1; m_addr = req_a; m_start = cyc; end
        else m_err = 1;
      end
      if (m_live && (cyc + 1 == m_start + longint'(LAT))) begin
        for (int b = 0; b < 3; b++) begin
          m_out[b] = m_mem[b][m_addr];
          if (m_bad[b][m_addr]) m_par = 1;
        end
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int sel, input int adr, input logic [HV_DIM-1:0] d);
    bus.LoadEn_SI   = 1'b1;
    bus.LoadSel_DI  = 2'(sel);
    bus.LoadAddr_DI = ADDR_W'(adr);
    bus.LoadData_DI = d;
    next_cycle();
    bus.LoadEn_SI   = 1'b0;
  endtask

  // lat = number of cycles from the current (request) cycle to the first valid one.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.RespValid_SO && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, sweep_cycles;
  logic [HV_DIM-1:0] pat, nd;

  initial begin
    bus.Req_SI = 1'b0; bus.ReqAddr_DI = '0; bus.LoadEn_SI = 1'b0;
    bus.LoadSel_DI = '0; bus.LoadAddr_DI = '0; bus.LoadData_DI = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_addr_err",   HV_DIM'(addr_err),         '0);
    chk("rst_valid",      HV_DIM'(bus.RespValid_SO), '0);
    chk("rst_im_out",     bus.IMOut_DO,              '0);
    chk("rst_load_ready", HV_DIM'(bus.LoadReady_SO), HV_DIM'(1));
    next_cycle();

    // Row 5 with fixed patterns, then a fetch at latency 2.
    pat = {(HV_DIM/2){2'b10}};
    do_load(0, 5, '1);
    do_load(1, 5, pat);
    do_load(2, 5, '0);
    bus.Req_SI = 1'b1; bus.ReqAddr_DI = 8'd5;
    wait_valid(lat);
    chk("row5_latency", HV_DIM'(lat), HV_DIM'(2));
    chk("row5_im",  bus.IMOut_DO,   '1);
    chk("row5_neg", bus.ProjNeg_DO, pat);
    chk("row5_pos", bus.ProjPos_DO, '0);
    next_cycle();
    bus.Req_SI = 1'b0;
    next_cycle();

    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 3; b++) do_load(b, a, rnd_hv());

    // Encoder-style sweep: advance one cycle after each valid.
    sweep_cycles = 0;
    for (int a = 0; a < 32; a++) begin
      bus.Req_SI = 1'b1; bus.ReqAddr_DI = ADDR_W'(a);
      wait_valid(lat);
      if (a == 0 || a == 31) chk("sweep_latency", HV_DIM'(lat), HV_DIM'(2));
      sweep_cycles += lat + 1;
      next_cycle();
    end
    chk("sweep_cycles", HV_DIM'(sweep_cycles), HV_DIM'(96));
    bus.Req_SI = 1'b0;
    next_cycle();

    // Load and request in the same idle cycle: write first, fetch next cycle.
    nd = rnd_hv();
    bus.Req_SI = 1'b1; bus.ReqAddr_DI = 8'd3;
    bus.LoadEn_SI = 1'b1; bus.LoadSel_DI = 2'd0; bus.LoadAddr_DI = 8'd3; bus.LoadData_DI = nd;
    next_cycle();
    bus.LoadEn_SI = 1'b0;
    wait_valid(lat);
    chk("ldreq_latency", HV_DIM'(lat), HV_DIM'(2));
    chk("ldreq_im", bus.IMOut_DO, nd);
    next_cycle();
    bus.Req_SI = 1'b0;
    next_cycle();

    // Abort during READ, then a clean fetch of row 7.
    bus.Req_SI = 1'b1; bus.ReqAddr_DI = 8'd10;
    next_cycle();
    bus.Req_SI = 1'b0;
    next_cycle();
    bus.Req_SI = 1'b1; bus.ReqAddr_DI = 8'd7;
    wait_valid(lat);
    chk("abort_then7_latency", HV_DIM'(lat), HV_DIM'(2));
    next_cycle();

    // Out-of-range request: sticky error until reset.
    bus.ReqAddr_DI = 8'd214;
    next_cycle();
    bus.Req_SI = 1'b0;
    next_cycle();
    bus.Req_SI = 1'b1;
    repeat (4) @(negedge clk);
    chk("oor_err",   HV_DIM'(addr_err),         HV_DIM'(1));
    chk("oor_valid", HV_DIM'(bus.RespValid_SO), '0);
    next_cycle();
    bus.Req_SI = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_addr_err",   HV_DIM'(addr_err),         '0);
    chk("rst2_im_out",     bus.IMOut_DO,              '0);
    chk("rst2_load_ready", HV_DIM'(bus.LoadReady_SO), HV_DIM'(1));
    next_cycle();

    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      rst = (r == 0);
      bus.LoadEn_SI   = (r >= 1) && (r < 12);
      bus.LoadSel_DI  = 2'($urandom_range(0, 3));
      bus.LoadAddr_DI = ADDR_W'(pick_addr());
      bus.LoadData_DI = rnd_hv();
      bus.Req_SI      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) == 0) bus.ReqAddr_DI = ADDR_W'(pick_addr());
      next_cycle();
    end
    rst = 1'b0; bus.Req_SI = 1'b0; bus.LoadEn_SI = 1'b0;
    repeat (3) next_cycle();

`ifdef IM_PARITY_EN
    dut.pos_mem[9][0] = ~dut.pos_mem[9][0];
    m_mem[2][9][0]    = ~m_mem[2][9][0];
    m_bad[2][9]       = 1;
    bus.Req_SI = 1'b1; bus.ReqAddr_DI = 8'd9;
    wait_valid(lat);
    chk("par_valid",     HV_DIM'(bus.RespValid_SO), HV_DIM'(1));
    chk("par_err_fetch", HV_DIM'(par_err),          HV_DIM'(1));
    next_cycle();
    bus.Req_SI = 1'b0;
`endif
    repeat (3) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
